// File: rtl/pipe_stall_arbiter.sv
// pipe_stall_arbiter: round-robin grant of two pipelines into one registered output slot, stalling the loser; `ARB_STALL_CNT_EN adds saturating stall counters
module pipe_stall_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_1,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic              in_valid_2,
  input  logic [DATA_W-1:0] in_data_2,
  output logic              stall_1,
  output logic              stall_2,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_1,
  output logic [CNT_W-1:0]  stall_cnt_2
`endif
);
  typedef enum logic {PRI1, PRI2} pri_t;
  pri_t state, state_nx;
  logic accept, grant_1, grant_2;
  always_comb begin
    accept = ~out_valid | out_ready;
    grant_1 = accept & in_valid_1 & (~in_valid_2 | state == PRI1);
    grant_2 = accept & in_valid_2 & (~in_valid_1 | state == PRI2);
    state_nx = (accept & in_valid_1 & in_valid_2) ? (state == PRI1 ? PRI2 : PRI1) : state;
    stall_1 = in_valid_1 & ~grant_1;
    stall_2 = in_valid_2 & ~grant_2;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PRI1;
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        out_valid <= grant_1 | grant_2;
        if (grant_1 | grant_2) begin
          out_data <= grant_2 ? in_data_2 : in_data_1;
          out_src <= grant_2;
        end
      end
    end
  end
`ifdef ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_1 <= '0;
      stall_cnt_2 <= '0;
    end else begin
      stall_cnt_1 <= stall_cnt_1 + CNT_W'(stall_1 & ~&stall_cnt_1);
      stall_cnt_2 <= stall_cnt_2 + CNT_W'(stall_2 & ~&stall_cnt_2);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stall_arbiter.sv
// tb_pipe_stall_arbiter: directed and random stimulus against a behavioural slot/round-robin model
module tb_pipe_stall_arbiter;
  logic clk = 0, reset = 1, v1 = 0, v2 = 0, rdy = 0;
  logic [31:0] d1 = 0, d2 = 0, out_data;
  logic stall_1, stall_2, out_valid, out_src;
`ifdef ARB_STALL_CNT_EN
  logic [3:0] stall_cnt_1, stall_cnt_2;
`endif
  int nchk = 0, nfail = 0;
  bit m_valid = 0, m_src = 0;
  logic [31:0] m_data = 0, held;
  int turn = 1, c1 = 0, c2 = 0;
  pipe_stall_arbiter #(.DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid_1(v1), .in_data_1(d1), .in_valid_2(v2), .in_data_2(d2),
    .stall_1(stall_1), .stall_2(stall_2),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(rdy)
`ifdef ARB_STALL_CNT_EN
    , .stall_cnt_1(stall_cnt_1), .stall_cnt_2(stall_cnt_2)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input bit r, input bit a, input bit b, input bit rd,
                      input logic [31:0] x1, input logic [31:0] x2);
    bit acc;
    int w;
    @(negedge clk);
    reset = r; v1 = a; v2 = b; rdy = rd; d1 = x1; d2 = x2;
    #1;
    acc = !m_valid || rd;
    w = !acc ? 0 : (a && b) ? turn : a ? 1 : b ? 2 : 0;
    chk("stall_1", stall_1, a && w != 1);
    chk("stall_2", stall_2, b && w != 2);
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_data = 0; m_src = 0; turn = 1; c1 = 0; c2 = 0;
    end else begin
      if (a && w != 1 && c1 < 15) c1++;
      if (b && w != 2 && c2 < 15) c2++;
      if (acc) begin
        m_valid = (w != 0);
        if (w != 0) begin
          m_data = (w == 1) ? x1 : x2;
          m_src = (w == 2);
        end
        if (a && b) turn = 3 - turn;
      end
    end
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_src", out_src, m_src);
`ifdef ARB_STALL_CNT_EN
    chk("stall_cnt_1", stall_cnt_1, c1);
    chk("stall_cnt_2", stall_cnt_2, c2);
`endif
  endtask
  initial begin
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    for (int i = 5; i <= 7; i++) begin
      step(0, 1, 0, 1, i, 32'hdead);
      chk("p1_data", out_data, i);
      chk("p1_src", out_src, 0);
    end
    step(1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 1, 1, $urandom, $urandom);
      chk("rr_src", out_src, k % 2);
    end
    held = out_data;
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1, 0, $urandom, $urandom);
      chk("full_stall", {stall_1, stall_2}, 2'b11);
      chk("hold_data", out_data, held);
    end
    step(0, 1, 1, 1, 32'h11, 32'h22);
    chk("resume_src", out_src, 0);
    chk("resume_data", out_data, 32'h11);
    step(0, 1, 0, 1, $urandom, $urandom);
    step(0, 1, 1, 0, $urandom, $urandom);
    step(1, 1, 1, 0, $urandom, $urandom);
    chk("midrst_valid", out_valid, 0);
    step(0, 1, 1, 1, 32'h33, 32'h44);
    chk("post_rst_src", out_src, 0);
    chk("post_rst_data", out_data, 32'h33);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom, $urandom);
`ifdef ARB_STALL_CNT_EN
    step(1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 1, $urandom, $urandom);
    for (int k = 0; k < 20; k++) step(0, 0, 1, 0, $urandom, $urandom);
    chk("sat_cnt_2", stall_cnt_2, 15);
    chk("sat_cnt_1", stall_cnt_1, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
